// File: rtl/beehive_rx_steer.sv
// -----------------------------------------------------------------------------
// beehive_rx_steer
//
// Frame-aware RX steering stage between the MAC-side AXI-Stream receive path
// and the Beehive engines. Every frame goes either to exactly one application
// channel, picked by its UDP destination port, or to the host bypass channel.
// Every output is registered. Backpressure is taken only from the outputs the
// current frame is steered to.
//
// Optional feature macro: BEEHIVE_RX_MIRROR_EN
//   defined   : a matched frame is also copied to bypass; the input waits for
//               both destinations, and stat_byp_frames counts every frame.
//   undefined : a matched frame goes to its application channel only.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   s_axis_rx_*                 receive stream from the MAC (tready is an output)
//   m_axis_byp_*                host bypass channel
//   m_axis_app_*                APP_COUNT application channels, flattened;
//                               channel i occupies slice i of each bus
//   cfg_port[APP_COUNT*16]      UDP destination port of each channel
//   cfg_en[APP_COUNT]           per-channel match enable
//   stat_app_frames             frames steered to any application channel (saturating)
//   stat_byp_frames             frames sent to bypass (saturating)
//   dbg_state                   FSM state (0 = FIRST, 1 = BODY)
//
// Handshake: a beat moves across an interface on a rising clock edge where
// tvalid and tready are both 1. Once tvalid is raised it stays high, and
// data/keep/last/user stay stable, until that beat is accepted. tready may
// change in any cycle.
// -----------------------------------------------------------------------------
module beehive_rx_steer #(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int USER_WIDTH = 1,
   parameter int APP_COUNT  = 2,
   parameter int CNT_W      = 32
) (
   input  logic                             clk,
   input  logic                             rst_n,

   input  logic [DATA_WIDTH-1:0]            s_axis_rx_tdata,
   input  logic [KEEP_WIDTH-1:0]            s_axis_rx_tkeep,
   input  logic                             s_axis_rx_tvalid,
   output logic                             s_axis_rx_tready,
   input  logic                             s_axis_rx_tlast,
   input  logic [USER_WIDTH-1:0]            s_axis_rx_tuser,

   output logic [DATA_WIDTH-1:0]            m_axis_byp_tdata,
   output logic [KEEP_WIDTH-1:0]            m_axis_byp_tkeep,
   output logic                             m_axis_byp_tvalid,
   input  logic                             m_axis_byp_tready,
   output logic                             m_axis_byp_tlast,
   output logic [USER_WIDTH-1:0]            m_axis_byp_tuser,

   output logic [APP_COUNT*DATA_WIDTH-1:0]  m_axis_app_tdata,
   output logic [APP_COUNT*KEEP_WIDTH-1:0]  m_axis_app_tkeep,
   output logic [APP_COUNT-1:0]             m_axis_app_tvalid,
   input  logic [APP_COUNT-1:0]             m_axis_app_tready,
   output logic [APP_COUNT-1:0]             m_axis_app_tlast,
   output logic [APP_COUNT*USER_WIDTH-1:0]  m_axis_app_tuser,

   input  logic [APP_COUNT*16-1:0]          cfg_port,
   input  logic [APP_COUNT-1:0]             cfg_en,

   output logic [CNT_W-1:0]                 stat_app_frames,
   output logic [CNT_W-1:0]                 stat_byp_frames,
   output logic [0:0]                       dbg_state
);

   // Destination index: 0..APP_COUNT-1 are the application channels,
   // APP_COUNT is the bypass channel.
   localparam int NDST = APP_COUNT + 1;
   localparam int BYP  = APP_COUNT;

   localparam logic [0:0] ST_FIRST = 1'b0;
   localparam logic [0:0] ST_BODY  = 1'b1;

   logic [0:0]            state;
   logic [NDST-1:0]       dst_mask;    // destinations of the frame in flight
   logic [NDST-1:0]       class_mask;  // destinations of the live beat-0
   logic [NDST-1:0]       cur_mask;
   logic [NDST-1:0]       dst_ready;
   logic [NDST-1:0]       dst_free;
   logic [NDST-1:0]       load;
   logic                  accept;
   logic                  first_beat;

   logic                  hdr_ok;
   logic [15:0]           dport;
   logic                  found;

   // One-entry output register per destination.
   logic [NDST-1:0]       out_valid;
   logic [NDST-1:0]       out_last;
   logic [DATA_WIDTH-1:0] out_data [NDST];
   logic [KEEP_WIDTH-1:0] out_keep [NDST];
   logic [USER_WIDTH-1:0] out_user [NDST];

   // ------------------------------------------------------------------
   // Header classification on the live beat. Byte n sits at tdata[8n+7:8n].
   // Only meaningful in FIRST; in BODY the latched mask is used instead.
   // ------------------------------------------------------------------
   always_comb begin
      hdr_ok = (s_axis_rx_tdata[103:96]  == 8'h08) &&   // ethertype hi
               (s_axis_rx_tdata[111:104] == 8'h00) &&   // ethertype lo
               (s_axis_rx_tdata[119:112] == 8'h45) &&   // IPv4, IHL 5
               (s_axis_rx_tdata[191:184] == 8'd17) &&   // protocol UDP
               (&s_axis_rx_tkeep[37:0]);                // header fully present
      dport = {s_axis_rx_tdata[295:288], s_axis_rx_tdata[303:296]};

      class_mask = '0;
      found      = 1'b0;
      // Lowest enabled channel whose port matches wins.
      for (int i = 0; i < APP_COUNT; i++) begin
         if (!found && hdr_ok && cfg_en[i] && (cfg_port[i*16 +: 16] == dport)) begin
            class_mask[i] = 1'b1;
            found         = 1'b1;
         end
      end
`ifdef BEEHIVE_RX_MIRROR_EN
      class_mask[BYP] = 1'b1;
`else
      class_mask[BYP] = !found;
`endif
   end

   // ------------------------------------------------------------------
   // Per-destination acceptance. A register is free when it is empty or is
   // being drained this cycle, so drain and load can happen together.
   // rst_n gates tready so nothing is accepted while reset is held.
   // ------------------------------------------------------------------
   assign dst_ready        = {m_axis_byp_tready, m_axis_app_tready};
   assign dst_free         = ~out_valid | dst_ready;
   assign cur_mask         = (state == ST_FIRST) ? class_mask : dst_mask;
   assign s_axis_rx_tready = rst_n & (&(dst_free | ~cur_mask));
   assign accept           = s_axis_rx_tvalid & s_axis_rx_tready;
   assign first_beat       = accept && (state == ST_FIRST);
   assign load             = accept ? cur_mask : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_FIRST;
         dst_mask        <= '0;
         stat_app_frames <= '0;
         stat_byp_frames <= '0;
         out_valid       <= '0;
         out_last        <= '0;
         for (int d = 0; d < NDST; d++) begin
            out_data[d] <= '0;
            out_keep[d] <= '0;
            out_user[d] <= '0;
         end
      end else begin
         if (accept) begin
            if (state == ST_FIRST) begin
               dst_mask <= class_mask;
            end
            state <= s_axis_rx_tlast ? ST_FIRST : ST_BODY;
         end

         if (first_beat) begin
            if ((|cur_mask[APP_COUNT-1:0]) && (stat_app_frames != {CNT_W{1'b1}})) begin
               stat_app_frames <= stat_app_frames + 1'b1;
            end
            if (cur_mask[BYP] && (stat_byp_frames != {CNT_W{1'b1}})) begin
               stat_byp_frames <= stat_byp_frames + 1'b1;
            end
         end

         for (int d = 0; d < NDST; d++) begin
            if (load[d]) begin
               out_valid[d] <= 1'b1;
               out_last[d]  <= s_axis_rx_tlast;
               out_data[d]  <= s_axis_rx_tdata;
               out_keep[d]  <= s_axis_rx_tkeep;
               out_user[d]  <= s_axis_rx_tuser;
            end else if (dst_ready[d]) begin
               out_valid[d] <= 1'b0;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Output mapping
   // ------------------------------------------------------------------
   for (genvar i = 0; i < APP_COUNT; i++) begin : g_app
      assign m_axis_app_tdata[i*DATA_WIDTH +: DATA_WIDTH] = out_data[i];
      assign m_axis_app_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH] = out_keep[i];
      assign m_axis_app_tuser[i*USER_WIDTH +: USER_WIDTH] = out_user[i];
      assign m_axis_app_tvalid[i]                         = out_valid[i];
      assign m_axis_app_tlast[i]                          = out_last[i];
   end

   assign m_axis_byp_tdata  = out_data[BYP];
   assign m_axis_byp_tkeep  = out_keep[BYP];
   assign m_axis_byp_tuser  = out_user[BYP];
   assign m_axis_byp_tvalid = out_valid[BYP];
   assign m_axis_byp_tlast  = out_last[BYP];

   assign dbg_state = state;

endmodule

// File: tb/tb_beehive_rx_steer.sv
`timescale 1ns/1ps
// Testbench for beehive_rx_steer: two application channels, 3-bit counters so
// saturation is reachable. Expected beats are queued per output when driven
// and compared as each output handshake is observed.
module tb_beehive_rx_steer;
   localparam int DW = 512;
   localparam int KW = 64;
   localparam int UW = 1;
   localparam int NA = 2;
   localparam int CW = 3;
   localparam int EW = DW + KW + UW + 1;   // {last, user, keep, data}

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0]    s_tdata = '0;
   logic [KW-1:0]    s_tkeep = '0;
   logic             s_tvalid = 1'b0;
   logic             s_tready;
   logic             s_tlast = 1'b0;
   logic [UW-1:0]    s_tuser = '0;
   logic [DW-1:0]    m_byp_tdata;
   logic [KW-1:0]    m_byp_tkeep;
   logic             m_byp_tvalid;
   logic             m_byp_tready = 1'b1;
   logic             m_byp_tlast;
   logic [UW-1:0]    m_byp_tuser;
   logic [NA*DW-1:0] m_app_tdata;
   logic [NA*KW-1:0] m_app_tkeep;
   logic [NA-1:0]    m_app_tvalid;
   logic [NA-1:0]    m_app_tready = '1;
   logic [NA-1:0]    m_app_tlast;
   logic [NA*UW-1:0] m_app_tuser;
   logic [NA*16-1:0] cfg_port = '0;
   logic [NA-1:0]    cfg_en = '0;
   logic [CW-1:0]    stat_app;
   logic [CW-1:0]    stat_byp;
   logic [0:0]       dbg_state;

   beehive_rx_steer #(
      .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .APP_COUNT(NA), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_rx_tdata(s_tdata), .s_axis_rx_tkeep(s_tkeep), .s_axis_rx_tvalid(s_tvalid),
      .s_axis_rx_tready(s_tready), .s_axis_rx_tlast(s_tlast), .s_axis_rx_tuser(s_tuser),
      .m_axis_byp_tdata(m_byp_tdata), .m_axis_byp_tkeep(m_byp_tkeep), .m_axis_byp_tvalid(m_byp_tvalid),
      .m_axis_byp_tready(m_byp_tready), .m_axis_byp_tlast(m_byp_tlast), .m_axis_byp_tuser(m_byp_tuser),
      .m_axis_app_tdata(m_app_tdata), .m_axis_app_tkeep(m_app_tkeep), .m_axis_app_tvalid(m_app_tvalid),
      .m_axis_app_tready(m_app_tready), .m_axis_app_tlast(m_app_tlast), .m_axis_app_tuser(m_app_tuser),
      .cfg_port(cfg_port), .cfg_en(cfg_en),
      .stat_app_frames(stat_app), .stat_byp_frames(stat_byp),
      .dbg_state(dbg_state)
   );

   // ---------------- scoreboard ----------------
   int errors = 0;
   int checks = 0;
   logic [EW-1:0] exp_app0_q[$];
   logic [EW-1:0] exp_app1_q[$];
   logic [EW-1:0] exp_byp_q[$];
   logic [CW-1:0] exp_app_cnt = '0;
   logic [CW-1:0] exp_byp_cnt = '0;
   bit            app_seen = 1'b0;

   logic          mon_v, mon_r, mon_empty;
   logic [EW-1:0] mon_got, mon_exp;

   // Output monitor: a beat with valid & ready at the falling edge transfers
   // on the next rising edge.
   always @(negedge clk) begin
      if (m_app_tvalid != '0) app_seen = 1'b1;
      if (rst_n) begin
         for (int ch = 0; ch < 3; ch++) begin
            mon_exp = '0;
            case (ch)
               0: begin
                  mon_v = m_app_tvalid[0]; mon_r = m_app_tready[0];
                  mon_got = {m_app_tlast[0], m_app_tuser[0 +: UW], m_app_tkeep[0 +: KW], m_app_tdata[0 +: DW]};
                  mon_empty = (exp_app0_q.size() == 0);
                  if (mon_v && mon_r && !mon_empty) mon_exp = exp_app0_q.pop_front();
               end
               1: begin
                  mon_v = m_app_tvalid[1]; mon_r = m_app_tready[1];
                  mon_got = {m_app_tlast[1], m_app_tuser[UW +: UW], m_app_tkeep[KW +: KW], m_app_tdata[DW +: DW]};
                  mon_empty = (exp_app1_q.size() == 0);
                  if (mon_v && mon_r && !mon_empty) mon_exp = exp_app1_q.pop_front();
               end
               default: begin
                  mon_v = m_byp_tvalid; mon_r = m_byp_tready;
                  mon_got = {m_byp_tlast, m_byp_tuser, m_byp_tkeep, m_byp_tdata};
                  mon_empty = (exp_byp_q.size() == 0);
                  if (mon_v && mon_r && !mon_empty) mon_exp = exp_byp_q.pop_front();
               end
            endcase
            if (mon_v && mon_r) begin
               checks++;
               if (mon_empty) begin
                  errors++;
                  $display("FAIL out_ch%0d unexpected beat at %0t: got last=%b data[63:0]=%h, expected none",
                           ch, $time, mon_got[EW-1], mon_got[63:0]);
               end else if (mon_got !== mon_exp) begin
                  errors++;
                  $display("FAIL out_ch%0d beat at %0t: got last=%b user=%b keep=%h data[127:0]=%h, expected last=%b user=%b keep=%h data[127:0]=%h",
                           ch, $time, mon_got[EW-1], mon_got[EW-2], mon_got[DW +: KW], mon_got[127:0],
                           mon_exp[EW-1], mon_exp[EW-2], mon_exp[DW +: KW], mon_exp[127:0]);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- model ----------------
   function automatic logic [7:0] get_byte(input logic [DW-1:0] d, input int n);
      return d[n*8 +: 8];
   endfunction

   // Returns {bypass, app1, app0} for a frame whose first beat is d/k.
   function automatic logic [2:0] model_dst(input logic [DW-1:0] d, input logic [KW-1:0] k);
      logic       m;
      logic [15:0] dp;
      logic [2:0] r;
      m  = (get_byte(d, 12) == 8'h08) && (get_byte(d, 13) == 8'h00) &&
           (get_byte(d, 14) == 8'h45) && (get_byte(d, 23) == 8'd17) && (&k[37:0]);
      dp = {get_byte(d, 36), get_byte(d, 37)};
      r  = 3'b100;
      if (m) begin
         if (cfg_en[0] && cfg_port[15:0] == dp)       r = 3'b001;
         else if (cfg_en[1] && cfg_port[31:16] == dp) r = 3'b010;
      end
`ifdef BEEHIVE_RX_MIRROR_EN
      if (r[1:0] != 2'b00) r[2] = 1'b1;
`endif
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   function automatic logic [DW-1:0] make_hdr(input logic [15:0] et, input logic [7:0] vi,
                                              input logic [7:0] proto, input logic [15:0] dp);
      logic [DW-1:0] d;
      d = rand_word();
      d[96 +: 8]  = et[15:8];
      d[104 +: 8] = et[7:0];
      d[112 +: 8] = vi;
      d[184 +: 8] = proto;
      d[288 +: 8] = dp[15:8];
      d[296 +: 8] = dp[7:0];
      return d;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic count_frame(input logic [2:0] dst);
      if (dst[1:0] != 2'b00 && exp_app_cnt != '1) exp_app_cnt++;
      if (dst[2] && exp_byp_cnt != '1) exp_byp_cnt++;
   endtask

   // Presents one beat and returns 1 ns after the edge that accepted it.
   task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                            input logic [UW-1:0] u, output bit ok);
      int  n;
      bit  hs;
      n = 0; ok = 1'b0;
      s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
      while (!ok && n < 200) begin
         @(negedge clk); hs = s_tready;
         @(posedge clk); #1;
         ok = hs; n++;
      end
      s_tvalid = 1'b0;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL send_beat: tready never seen within %0d cycles, expected acceptance", n);
      end
   endtask

   task automatic send_tracked(input logic [2:0] dst, input logic [DW-1:0] d, input logic [KW-1:0] k,
                               input logic l, output bit ok);
      logic [UW-1:0] u;
      u = UW'($urandom_range(0, 1));
      if (dst[0]) exp_app0_q.push_back({l, u, k, d});
      if (dst[1]) exp_app1_q.push_back({l, u, k, d});
      if (dst[2]) exp_byp_q.push_back({l, u, k, d});
      send_beat(d, k, l, u, ok);
   endtask

   task automatic send_frame(input logic [DW-1:0] hdr, input logic [KW-1:0] k0, input int nb,
                             input bit lat_chk);
      logic [2:0]    dst;
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
      bit            ok;
      dst = model_dst(hdr, k0);
      count_frame(dst);
      for (int b = 0; b < nb; b++) begin
         d = (b == 0) ? hdr : rand_word();
         l = (b == nb - 1);
         k = (b == 0) ? k0 : (l ? 64'h0000_0000_ffff_ffff : '1);
         send_tracked(dst, d, k, l, ok);
         if (ok && lat_chk) begin
            checks++;
            if ({m_byp_tvalid, m_app_tvalid} !== dst) begin
               errors++;
               $display("FAIL latency beat %0d: valid {byp,app1,app0}=%b, expected %b", b,
                        {m_byp_tvalid, m_app_tvalid}, dst);
            end
         end
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_app0_q.size() + exp_app1_q.size() + exp_byp_q.size()) != 0 && n < 300) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      checks++;
      if ((exp_app0_q.size() + exp_app1_q.size() + exp_byp_q.size()) != 0) begin
         errors++;
         $display("FAIL %s drain: %0d/%0d/%0d beats still outstanding, expected 0/0/0", name,
                  exp_app0_q.size(), exp_app1_q.size(), exp_byp_q.size());
      end
   endtask

   task automatic check_counters(input string name);
      checks++;
      if (stat_app !== exp_app_cnt || stat_byp !== exp_byp_cnt) begin
         errors++;
         $display("FAIL %s counters: app=%0d byp=%0d, expected app=%0d byp=%0d", name,
                  stat_app, stat_byp, exp_app_cnt, exp_byp_cnt);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({m_byp_tvalid, m_app_tvalid} !== 3'b000 || s_tready !== 1'b0) begin
         errors++;
         $display("FAIL reset valids: valid=%b tready=%b, expected 000 and 0", {m_byp_tvalid, m_app_tvalid}, s_tready);
      end
      checks++;
      if (m_byp_tdata !== '0 || m_app_tdata !== '0 || m_app_tkeep !== '0 || m_byp_tkeep !== '0 ||
          m_app_tlast !== '0 || m_byp_tlast !== 1'b0 || m_app_tuser !== '0 || m_byp_tuser !== '0) begin
         errors++;
         $display("FAIL reset payload: outputs not all zero (byp_data[63:0]=%h app_data[63:0]=%h), expected 0",
                  m_byp_tdata[63:0], m_app_tdata[63:0]);
      end
      check_counters("reset");
      checks++;
      if (dbg_state !== 1'b0) begin
         errors++;
         $display("FAIL reset state: %b, expected 0", dbg_state);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_udp_app();
      cfg_port = {16'h5678, 16'h1234};
      cfg_en   = 2'b11;
      send_frame(make_hdr(16'h0800, 8'h45, 8'd17, 16'h5678), '1, 3, 1'b1);
      drain("udp_app");
      check_counters("udp_app");
   endtask

   task automatic test_bypass();
      app_seen = 1'b0;
      send_frame(make_hdr(16'h86dd, 8'h45, 8'd17, 16'h5678), '1, 2, 1'b1);
      drain("bypass");
      check_counters("bypass");
      checks++;
      if (app_seen !== 1'b0) begin
         errors++;
         $display("FAIL bypass app_valid: app tvalid seen=%b, expected 0", app_seen);
      end
   endtask

   task automatic test_cfg_flip();
      logic [DW-1:0] hdr;
      logic [2:0]    dst;
      bit            ok;
      cfg_port = {16'h1234, 16'h1234};
      cfg_en   = 2'b11;
      hdr = make_hdr(16'h0800, 8'h45, 8'd17, 16'h1234);
      dst = model_dst(hdr, '1);
      count_frame(dst);
      send_tracked(dst, hdr, '1, 1'b0, ok);
      checks++;
      if (dbg_state !== 1'b1) begin
         errors++;
         $display("FAIL cfg_flip state after beat0: %b, expected 1", dbg_state);
      end
      send_tracked(dst, rand_word(), '1, 1'b0, ok);
      cfg_port[15:0] = 16'h9999;
      send_tracked(dst, rand_word(), 64'h0000_0000_0000_ffff, 1'b1, ok);
      checks++;
      if (dbg_state !== 1'b0) begin
         errors++;
         $display("FAIL cfg_flip state after last: %b, expected 0", dbg_state);
      end
      // The new port set applies from the next frame on.
      send_frame(make_hdr(16'h0800, 8'h45, 8'd17, 16'h1234), '1, 2, 1'b1);
      drain("cfg_flip");
      check_counters("cfg_flip");
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] held;
      cfg_port = {16'h5678, 16'h1234};
      cfg_en   = 2'b11;
      fork
         begin
            send_frame(make_hdr(16'h0800, 8'h45, 8'd17, 16'h1234), '1, 5, 1'b0);
            send_frame(make_hdr(16'h0806, 8'h45, 8'd17, 16'h1234), '1, 2, 1'b0);
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            m_app_tready[0] = 1'b0;
            #1;
            held = m_app_tdata[DW-1:0];
            for (int i = 0; i < 10; i++) begin
               checks++;
               if (s_tready !== 1'b0 || m_app_tvalid[0] !== 1'b1 || m_app_tdata[DW-1:0] !== held) begin
                  errors++;
                  $display("FAIL backpressure cycle %0d: tready=%b app0_valid=%b data_stable=%b, expected 0/1/1",
                           i, s_tready, m_app_tvalid[0], (m_app_tdata[DW-1:0] === held));
               end
               @(posedge clk); #2;
            end
            m_app_tready[0] = 1'b1;
         end
      join
      drain("backpressure");
      check_counters("backpressure");
   endtask

   task automatic test_boundaries();
      logic [KW-1:0] k;
      cfg_port = {16'h5678, 16'h1234};
      cfg_en   = 2'b11;
      k = '1; k[37] = 1'b0;
      send_frame(make_hdr(16'h0800, 8'h45, 8'd17, 16'h1234), k, 1, 1'b1);    // header truncated
      send_frame(make_hdr(16'h0800, 8'h46, 8'd17, 16'h1234), '1, 1, 1'b1);   // IHL 6
      send_frame(make_hdr(16'h0800, 8'h45, 8'd6,  16'h1234), '1, 1, 1'b1);   // TCP
      send_frame(make_hdr(16'h0801, 8'h45, 8'd17, 16'h1234), '1, 1, 1'b1);   // ethertype lo byte
      cfg_port = {16'h1234, 16'h1234};
      cfg_en   = 2'b10;
      send_frame(make_hdr(16'h0800, 8'h45, 8'd17, 16'h1234), '1, 1, 1'b1);   // ch0 disabled -> ch1
      cfg_en   = 2'b00;
      send_frame(make_hdr(16'h0800, 8'h45, 8'd17, 16'h1234), '1, 1, 1'b1);   // none enabled
      drain("boundaries");
      check_counters("boundaries");
   endtask

   task automatic test_saturation();
      cfg_port = {16'h5678, 16'h1234};
      cfg_en   = 2'b11;
      for (int i = 0; i < 9; i++) begin
         send_frame(make_hdr(16'h0800, 8'h45, 8'd17, 16'h1234), '1, 1, 1'b0);
         send_frame(make_hdr(16'h0806, 8'h45, 8'd17, 16'h1234), '1, 1, 1'b0);
      end
      drain("saturation");
      check_counters("saturation");
      checks++;
      if (stat_app !== 3'b111 || stat_byp !== 3'b111) begin
         errors++;
         $display("FAIL saturation: app=%0d byp=%0d, expected 7 and 7", stat_app, stat_byp);
      end
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      cfg_port = {16'h5678, 16'h1234};
      cfg_en   = 2'b11;
      send_beat(make_hdr(16'h0800, 8'h45, 8'd17, 16'h1234), '1, 1'b0, '0, ok);
      rst_n = 1'b0;
      #1;
      exp_app0_q.delete(); exp_app1_q.delete(); exp_byp_q.delete();
      exp_app_cnt = '0; exp_byp_cnt = '0;
      checks++;
      if ({m_byp_tvalid, m_app_tvalid} !== 3'b000 || s_tready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid valids: valid=%b tready=%b, expected 000 and 0", {m_byp_tvalid, m_app_tvalid}, s_tready);
      end
      check_counters("reset_mid");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      // This first beat must be classified afresh, so it goes to bypass.
      send_frame(make_hdr(16'h0806, 8'h45, 8'd17, 16'h1234), '1, 2, 1'b1);
      drain("reset_mid");
      check_counters("after_reset_mid");
   endtask

   task automatic test_back_to_back();
      bit            stim_done;
      logic [15:0]   dp;
      logic [15:0]   et;
      cfg_port = {16'h5678, 16'h1234};
      cfg_en   = 2'b11;
      stim_done = 1'b0;
      fork
         begin
            for (int f = 0; f < 8; f++) begin
               case ($urandom_range(0, 2))
                  0:       dp = 16'h1234;
                  1:       dp = 16'h5678;
                  default: dp = 16'h4321;
               endcase
               et = ($urandom_range(0, 3) == 0) ? 16'h86dd : 16'h0800;
               send_frame(make_hdr(et, 8'h45, 8'd17, dp), '1, $urandom_range(1, 4), 1'b0);
            end
            stim_done = 1'b1;
         end
         begin
            for (int c = 0; c < 2000 && !stim_done; c++) begin
               @(posedge clk); #1;
               m_app_tready = NA'($urandom_range(0, 3));
               m_byp_tready = 1'($urandom_range(0, 1));
            end
            m_app_tready = '1;
            m_byp_tready = 1'b1;
         end
      join
      drain("back_to_back");
      check_counters("back_to_back");
   endtask

`ifdef BEEHIVE_RX_MIRROR_EN
   task automatic test_mirror();
      cfg_port = {16'h5678, 16'h1234};
      cfg_en   = 2'b11;
      m_byp_tready = 1'b0;
      fork
         send_frame(make_hdr(16'h0800, 8'h45, 8'd17, 16'h1234), '1, 3, 1'b0);
         begin
            @(posedge clk); #2;
            for (int i = 0; i < 5; i++) begin
               checks++;
               if (s_tready !== 1'b0) begin
                  errors++;
                  $display("FAIL mirror stall cycle %0d: tready=%b, expected 0", i, s_tready);
               end
               @(posedge clk); #2;
            end
            m_byp_tready = 1'b1;
         end
      join
      drain("mirror");
      check_counters("mirror");
   endtask
`endif

   initial begin
      test_reset();
      test_udp_app();
      test_bypass();
      test_cfg_flip();
      test_backpressure();
      test_boundaries();
`ifdef BEEHIVE_RX_MIRROR_EN
      test_mirror();
`endif
      test_back_to_back();
      test_reset_mid_frame();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
